// File: rtl/pipe_cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// GROUP_W is the lookahead group width; num_stages() gives the pipeline depth.
package pipe_cla_pkg;

  // Width of one carry-lookahead group in bits.
  localparam int GROUP_W = 4;

  // Number of pipeline stages for a given operand width and groups per stage.
  function automatic int num_stages(input int width, input int gps);
    return width / (GROUP_W * gps);
  endfunction

  // Number of operand bits a stage still has to hand on after resolving its
  // own groups (stage index k, counting from 0).
  function automatic int rem_bits(input int width, input int gps, input int k);
    return width - (k + 1) * GROUP_W * gps;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group, purely combinational.
// Every internal carry is a two-level sum of products of the per-bit
// generate/propagate terms and the group carry-in; nothing ripples.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       gg,
  output logic       gp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Per-bit generate/propagate, flat lookahead carries, group terms and sum.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
    co   = gg | (gp & ci);
    s    = p ^ c;
  end

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Stage k resolves GPS lookahead groups and registers the partial sum, the
// carry into the next stage and the operand bits not yet consumed.  A single
// global stall (result held, downstream not ready) freezes every stage.
// Optional feature: define PIPE_CLA_OVF_EN to add the registered signed
// overflow output ovf.
module pipe_cla_adder
  import pipe_cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int S  = num_stages(WIDTH, GPS);
  localparam int SW = GROUP_W * GPS;

  logic             stall;
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtraction is a + ~b + 1; cin only matters for addition.
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub ? 1'b1 : cin;
  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  genvar gi, gj;

  for (gi = 0; gi < S; gi++) begin : g_stage
    localparam int REM_IN   = WIDTH - gi * SW;
    localparam int DONE_OUT = (gi + 1) * SW;

    logic [REM_IN-1:0]   a_in;
    logic [REM_IN-1:0]   b_in;
    logic                c_in;
    logic                v_in;
    logic [SW-1:0]       s_slice;
    logic [DONE_OUT-1:0] sum_cat;
    logic [GPS:0]        c_chain;
    logic [GPS-1:0]      gg_w;
    logic [GPS-1:0]      gp_w;
    logic                gprop_unused;
    logic                v_reg;
    logic                c_reg;
    logic [DONE_OUT-1:0] sum_reg;

    // Stage 0 takes the raw beat; later stages take the previous registers.
    if (gi == 0) begin : g_src
      assign a_in    = a;
      assign b_in    = b_eff;
      assign c_in    = c_eff;
      assign v_in    = in_valid;
      assign sum_cat = s_slice;
    end else begin : g_src
      assign a_in    = g_stage[gi-1].g_fwd.a_reg;
      assign b_in    = g_stage[gi-1].g_fwd.b_reg;
      assign c_in    = g_stage[gi-1].c_reg;
      assign v_in    = g_stage[gi-1].v_reg;
      assign sum_cat = {s_slice, g_stage[gi-1].sum_reg};
    end

    // The groups of one stage are chained through their lookahead carry-out.
    assign c_chain[0] = c_in;
    for (gj = 0; gj < GPS; gj++) begin : g_grp
      cla_group4 u_grp (
        .a  (a_in[gj*GROUP_W +: GROUP_W]),
        .b  (b_in[gj*GROUP_W +: GROUP_W]),
        .ci (c_chain[gj]),
        .s  (s_slice[gj*GROUP_W +: GROUP_W]),
        .co (c_chain[gj+1]),
        .gg (gg_w[gj]),
        .gp (gp_w[gj])
      );
    end

    // Group generate/propagate are already folded into co inside each group.
    assign gprop_unused = ^{gg_w, gp_w};

    // Stage valid, carry and accumulated sum; data only loads for real beats.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_reg   <= 1'b0;
        c_reg   <= 1'b0;
        sum_reg <= '0;
      end else if (advance) begin
        v_reg <= v_in;
        if (v_in) begin
          c_reg   <= c_chain[GPS];
          sum_reg <= sum_cat;
        end
      end
    end

    // Operand bits still needed by later stages travel with the beat.
    if (gi < S - 1) begin : g_fwd
      logic [REM_IN-SW-1:0] a_reg;
      logic [REM_IN-SW-1:0] b_reg;

      // Forward the unconsumed operand bits alongside the partial sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (advance && v_in) begin
          a_reg <= a_in[REM_IN-1:SW];
          b_reg <= b_in[REM_IN-1:SW];
        end
      end
    end

`ifdef PIPE_CLA_OVF_EN
    if (gi == S - 1) begin : g_ovf
      logic msb_cin;
      logic ovf_reg;

      // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
      assign msb_cin = s_slice[SW-1] ^ a_in[SW-1] ^ b_in[SW-1];

      // Signed overflow, registered in step with the final sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (advance && v_in) begin
          ovf_reg <= msb_cin ^ c_chain[GPS];
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[S-1].v_reg;
  assign sum       = g_stage[S-1].sum_reg;
  assign cout      = g_stage[S-1].c_reg;
`ifdef PIPE_CLA_OVF_EN
  assign ovf       = g_stage[S-1].g_ovf.ovf_reg;
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder, WIDTH=16, GPS=1 (four stages).
// Directed vectors with hand-computed results; a monitor pops the queue on
// every accepted result.  Define PIPE_CLA_OVF_EN to also check ovf.
module tb_pipe_cla_adder;

  localparam int WIDTH = 16;
  localparam int S     = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_CLA_OVF_EN
  logic             ovf;
`endif

  pipe_cla_adder #(.WIDTH(WIDTH), .GPS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_CLA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t0;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[8];
  vec_t bp[5];
  int   checks  = 0;
  int   passes  = 0;
  int   cyc     = 0;
  int   run_len = 0;
  int   max_run = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  // Monitor: compares every result the DUT hands downstream.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got sum 0x%04h cout %0b, want no result", sum, cout);
        end else begin
          mon_e = sb_q.pop_front();
          $display("beat out @%0d: sum=0x%04h cout=%0b (expect 0x%04h/%0b)",
                   cyc, sum, cout, mon_e.s, mon_e.c);
          chk("result", {15'd0, cout, sum}, {15'd0, mon_e.c, mon_e.s});
`ifdef PIPE_CLA_OVF_EN
          chk("ovf", {31'd0, ovf}, {31'd0, mon_e.o});
`endif
          if (mon_e.lat) chk("latency", cyc - mon_e.t0, S);
        end
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      input logic ts, input logic [15:0] es, input logic ec,
                      input logic eo, input bit push, input bit lat);
    int budget;
    budget   = 0;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    sub      = ts;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, want 1", budget);
    end else if (push) begin
      exp_t e;
      e.s = es; e.c = ec; e.o = eo; e.t0 = cyc; e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget   = 0;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && budget < 64) begin
      @(posedge clk);
      budget++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0},
      '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
      '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0},
      '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0},
      '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0},
      '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0}
    };
    bp = '{
      '{16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0},
      '{16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0},
      '{16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
      '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1}
    };

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single beat, first-result latency.
    send(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Wrap-around and subtraction corners.
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();

    // Eight back-to-back beats.
    max_run = 0;
    for (int i = 0; i < 8; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, vecs[i].es, vecs[i].ec,
           vecs[i].eo, 1'b1, 1'b1);
    drain();
    chk("b2b_run", max_run, 8);

    // Backpressure with a full pipe.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(bp[i].a, bp[i].b, bp[i].ci, bp[i].sb, bp[i].es, bp[i].ec, bp[i].eo, 1'b1, 1'b0);
    fork
      send(bp[4].a, bp[4].b, bp[4].ci, bp[4].sb, bp[4].es, bp[4].ec, bp[4].eo, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
          chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_sum_hold", {16'd0, sum}, {16'd0, bp[0].es});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight.
    out_ready = 1'b0;
    send(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h2222, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h3333, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'd0, sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, cout}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    repeat (6) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; a multiple of 4, range 4..64.
REQ-002 SHALL have parameter GPS, default 1: number of 4-bit lookahead groups per pipeline stage; WIDTH/4 SHALL be a multiple of GPS.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: the operand beat is valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a beat this cycle.
REQ-007 SHALL have port a, input, WIDTH: the first operand.
REQ-008 SHALL have port b, input, WIDTH: the second operand.
REQ-009 SHALL have port cin, input, 1: the carry-in, used when sub=0.
REQ-010 SHALL have port sub, input, 1: 1 selects a-b, 0 selects a+b+cin.
REQ-011 SHALL have port out_valid, output, 1: the result beat is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port sum, output, WIDTH: the result.
REQ-014 SHALL have port cout, output, 1: the carry out of the MSB; for subtraction it is the inverted borrow.

Function
REQ-015 SHALL compute the result with sub=0 as {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-016 SHALL compute the result with sub=1 as {cout,sum} = a + ~b + 1, ignoring cin.
REQ-017 SHALL generate the carries inside each 4-bit group with full lookahead from per-bit generate (a&b) and propagate (a^b), with no ripple inside a group.
REQ-018 SHALL have S = WIDTH/(4*GPS) pipeline stages; stage k resolves groups k*GPS..k*GPS+GPS-1 and registers the partial sum, the carry into the next stage, and the not-yet-used operand bits.
REQ-019 SHALL have a latency of exactly S cycles from an accepted beat (in_valid&in_ready) to out_valid for that beat, in the absence of backpressure.
REQ-020 SHALL sustain a throughput of one beat per cycle while out_ready=1.
REQ-021 SHALL define stall = out_valid & ~out_ready; while stall=1, all stages SHALL hold and in_ready=0.
REQ-022 SHALL drive in_ready = ~stall, combinationally.
REQ-023 SHALL keep sum and cout stable while out_valid=1 and out_ready=0.
REQ-024 SHALL let pipeline bubbles travel with valid=0, and their data SHALL NOT be observable as a valid result.
REQ-025 SHALL drop a beat presented with in_valid=1 while in_ready=0, and the source SHALL hold the beat until it is accepted.
REQ-026 SHALL let a valid beat in the last stage leave on out_ready=1 while, in the same cycle, a new beat enters stage 0.
REQ-027 SHALL treat the all-ones + 1 case as wrap-around: sum=0 and cout=1.

Reset
REQ-028 SHALL, on rst asserted (asynchronously), clear all stage valid bits, out_valid, sum and cout to 0.
REQ-029 SHALL drive in_ready=1 during reset and after reset.
REQ-030 SHALL discard all in-flight beats on a reset mid-operation, and the first result after release SHALL come from a beat accepted after release.

Configuration
REQ-031 SHALL, with macro PIPE_CLA_OVF_EN defined, add output ovf (1 bit) = signed overflow of the selected operation (carry into the MSB XOR carry out of the MSB), registered with sum and cleared by reset.
REQ-032 SHALL have no ovf port and no overflow logic when PIPE_CLA_OVF_EN is undefined.

Structure
REQ-033 SHALL take GROUP_W=4 and the stage-count function from the shared package pipe_cla_pkg.
REQ-034 SHALL use one combinational sub-module, cla_group4: inputs a[3:0], b[3:0], ci; outputs s[3:0], co, gg (group generate) and gp (group propagate); it is instantiated WIDTH/4 times.

Verification
REQ-035 SHALL cover, for WIDTH=16 and GPS=1 (S=4): a=0x1234, b=0x1111, cin=1, sub=0 -> sum=0x2346, cout=0, out_valid exactly 4 cycles after acceptance.
REQ-036 SHALL cover a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; with PIPE_CLA_OVF_EN defined, ovf=0.
REQ-037 SHALL cover a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; and a=0x7FFF, b=0xFFFF, sub=1 -> sum=0x8000, ovf=1.
REQ-038 SHALL cover 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles, in order, results matching.
REQ-039 SHALL cover holding out_ready=0 for 3 cycles while the pipe is full -> in_ready=0, sum held, no beat lost or duplicated after release.
REQ-040 SHALL cover asserting rst with 3 beats in flight -> out_valid=0 at once, and none of those 3 beats appears after release.
